// File: rtl/noc_injector.sv
// noc_injector
// Endpoint-to-router injection stage. Takes a valid/ready flit stream from a
// local endpoint, tags every flit with its packet's destination and tail
// marker, and drives one router input port under credit-based flow control.
// Packets are kept atomic: the destination latched from the head flit is
// reused for every body flit.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      endpoint flit valid
//   in_ready      injector can accept a flit
//   in_data       flit payload
//   in_dest       destination, sampled on head flits only
//   in_last       last flit of the packet
//   data_out      to router data_in
//   dest_out      to router dest_in
//   is_tail_out   to router is_tail_in
//   send_out      to router send_in, one pulse per flit
//   credit_in     from router credit_out, one pulse per freed buffer slot
//   credit_err    sticky, a credit arrived with the counter already full
//   pkt_err       sticky, a packet was truncated (length-limited build only)
//
// Optional feature: define NOC_INJECTOR_MAXLEN_EN to enable the per-packet
// length limit (MAX_PACKET_FLITS) with truncation and a DROP state.

module noc_injector #(
  parameter int FLIT_WIDTH        = 256,
  parameter int DEST_WIDTH        = 3,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int MAX_PACKET_FLITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLIT_WIDTH-1:0] in_data,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic                  in_last,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic                  credit_err,
  output logic                  pkt_err
);

  localparam int CNT_W = $clog2(FLIT_BUFFER_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FLIT_BUFFER_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    DROP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        credCnt_q, credCnt_d;
  logic [DEST_WIDTH-1:0]   headDest_q, headDest_d;
  logic                    credErr_q, credErr_d;
  logic [FLIT_WIDTH-1:0]   data_q, data_d;
  logic [DEST_WIDTH-1:0]   dest_q, dest_d;
  logic                    tail_q, tail_d;
  logic                    send_q, send_d;
  logic                    readyRaw;
  logic                    fire;
  logic                    sendFire;

`ifdef NOC_INJECTOR_MAXLEN_EN
  localparam int FCNT_W = $clog2(MAX_PACKET_FLITS + 1);
  localparam logic [FCNT_W-1:0] LEN_MAX = FCNT_W'(MAX_PACKET_FLITS);

  logic [FCNT_W-1:0]       flitCnt_q, flitCnt_d;
  logic                    pktErr_q, pktErr_d;
  logic [FCNT_W-1:0]       pktLen;
  logic                    trunc;
`endif

  // Readiness comes only from registered state, so credit_in never reaches
  // in_ready combinationally. rst_n gates just the output; the internal
  // handshake does not need it because every flop is held in reset anyway.
  assign readyRaw = (state_q == DROP) || (credCnt_q != '0);
  assign in_ready = rst_n & readyRaw;
  assign fire     = in_valid & readyRaw;
  assign sendFire = fire & (state_q != DROP);

  // Next-state logic: credit accounting, packet FSM and the output register.
  always_comb begin
    state_d    = state_q;
    credCnt_d  = credCnt_q;
    headDest_d = headDest_q;
    credErr_d  = credErr_q;
    data_d     = data_q;
    dest_d     = dest_q;
    tail_d     = tail_q;
    send_d     = 1'b0;
`ifdef NOC_INJECTOR_MAXLEN_EN
    flitCnt_d  = flitCnt_q;
    pktErr_d   = pktErr_q;
    pktLen     = (state_q == IDLE) ? FCNT_W'(1) : flitCnt_q + 1'b1;
    trunc      = sendFire && !in_last && (pktLen == LEN_MAX);
`endif

    // A credit and a send in the same cycle cancel out. A lone credit on a
    // full counter means the router returned more than it was given.
    if (credit_in && !sendFire) begin
      if (credCnt_q == CNT_FULL) begin
        credErr_d = 1'b1;
      end else begin
        credCnt_d = credCnt_q + 1'b1;
      end
    end else if (!credit_in && sendFire) begin
      credCnt_d = credCnt_q - 1'b1;
    end

    if (sendFire) begin
      send_d = 1'b1;
      data_d = in_data;
      tail_d = in_last;
      if (state_q == IDLE) begin
        dest_d = in_dest;
        if (!in_last) begin
          headDest_d = in_dest;
        end
      end else begin
        dest_d = headDest_q;
      end
      state_d = in_last ? IDLE : BODY;
`ifdef NOC_INJECTOR_MAXLEN_EN
      flitCnt_d = pktLen;
      if (trunc) begin
        tail_d   = 1'b1;
        pktErr_d = 1'b1;
        state_d  = DROP;
      end
`endif
    end
`ifdef NOC_INJECTOR_MAXLEN_EN
    else if (fire && in_last) begin
      // Rest of an over-long packet is swallowed until its own tail.
      state_d = IDLE;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      credCnt_q  <= CNT_FULL;
      headDest_q <= '0;
      credErr_q  <= 1'b0;
      data_q     <= '0;
      dest_q     <= '0;
      tail_q     <= 1'b0;
      send_q     <= 1'b0;
`ifdef NOC_INJECTOR_MAXLEN_EN
      flitCnt_q  <= '0;
      pktErr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      credCnt_q  <= credCnt_d;
      headDest_q <= headDest_d;
      credErr_q  <= credErr_d;
      data_q     <= data_d;
      dest_q     <= dest_d;
      tail_q     <= tail_d;
      send_q     <= send_d;
`ifdef NOC_INJECTOR_MAXLEN_EN
      flitCnt_q  <= flitCnt_d;
      pktErr_q   <= pktErr_d;
`endif
    end
  end

  assign data_out    = data_q;
  assign dest_out    = dest_q;
  assign is_tail_out = tail_q;
  assign send_out    = send_q;
  assign credit_err  = credErr_q;
`ifdef NOC_INJECTOR_MAXLEN_EN
  assign pkt_err     = pktErr_q;
`else
  assign pkt_err     = 1'b0;
`endif

endmodule

// File: tb/tb_noc_injector.sv
// tb_noc_injector
// Self-checking bench for noc_injector. A packet-level reference model tracks
// credits, packet position and the expected router-side outputs; a compare
// process checks the DUT against it every cycle, and directed scenarios add
// literal expectations on top. Ends with a randomized traffic phase.

module tb_noc_injector;

  localparam int FW    = 256;
  localparam int DW    = 3;
  localparam int DEPTH = 2;
  localparam int MAXF  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] in_data = '0;
  logic [DW-1:0] in_dest = '0;
  logic          in_last = 1'b0;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in = 1'b0;
  logic          credit_err;
  logic          pkt_err;

  int checkCount = 0;
  int errorCount = 0;
  bit cmpEn = 1'b0;
  int autoCredit = 0;

  // Reference model state
  int            credM;
  bit            inPktM, dropM, credErrM, pktErrM;
  int            lenM;
  logic [DW-1:0] headM;
  logic          expSend, expTail;
  logic [FW-1:0] expData;
  logic [DW-1:0] expDest;

  always #5 clk = ~clk;

  noc_injector #(
    .FLIT_WIDTH       (FW),
    .DEST_WIDTH       (DW),
    .FLIT_BUFFER_DEPTH(DEPTH),
    .MAX_PACKET_FLITS (MAXF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_last    (in_last),
    .data_out   (data_out),
    .dest_out   (dest_out),
    .is_tail_out(is_tail_out),
    .send_out   (send_out),
    .credit_in  (credit_in),
    .credit_err (credit_err),
    .pkt_err    (pkt_err)
  );

  task automatic checkOutput(input string name, input logic [FW-1:0] act,
                             input logic [FW-1:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: one accepted flit per cycle at most, credits as a
  // plain integer, packet position as a flag plus a flit count.
  always @(posedge clk or negedge rst_n) begin : refModel
    automatic bit rdy, fireL, sendL, trunc;
    automatic int idx, credNext;
    if (!rst_n) begin
      credM    <= DEPTH;
      inPktM   <= 1'b0;
      dropM    <= 1'b0;
      credErrM <= 1'b0;
      pktErrM  <= 1'b0;
      lenM     <= 0;
      headM    <= '0;
      expSend  <= 1'b0;
      expTail  <= 1'b0;
      expData  <= '0;
      expDest  <= '0;
    end else begin
      rdy   = dropM || (credM > 0);
      fireL = in_valid && rdy;
      sendL = fireL && !dropM;
      expSend <= sendL;
      credNext = credM + int'(credit_in) - int'(sendL);
      if (credNext > DEPTH) begin
        credNext = DEPTH;
        credErrM <= 1'b1;
      end
      credM <= credNext;
      if (sendL) begin
        idx   = inPktM ? lenM + 1 : 1;
        trunc = 1'b0;
`ifdef NOC_INJECTOR_MAXLEN_EN
        trunc = !in_last && (idx == MAXF);
`endif
        expData <= in_data;
        expDest <= inPktM ? headM : in_dest;
        expTail <= in_last || trunc;
        if (!inPktM) headM <= in_dest;
        lenM <= idx;
        if (in_last) begin
          inPktM <= 1'b0;
        end else if (trunc) begin
          inPktM  <= 1'b0;
          dropM   <= 1'b1;
          pktErrM <= 1'b1;
        end else begin
          inPktM <= 1'b1;
        end
      end else if (fireL && in_last) begin
        dropM <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("send_out", send_out, expSend);
      checkOutput("data_out", data_out, expData);
      checkOutput("dest_out", dest_out, expDest);
      checkOutput("is_tail_out", is_tail_out, expTail);
      checkOutput("in_ready", in_ready, rst_n && (dropM || credM > 0));
      checkOutput("credit_err", credit_err, credErrM);
      checkOutput("pkt_err", pkt_err, pktErrM);
    end
  end

  // Router-side credit return: 0 none, 1 random, 2 whenever a slot is owed.
  task automatic setCredit();
    case (autoCredit)
      0:       credit_in = 1'b0;
      1:       credit_in = (credM < DEPTH) && ($urandom_range(0, 2) != 0);
      default: credit_in = (credM < DEPTH);
    endcase
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      setCredit();
      @(negedge clk);
    end
    credit_in = 1'b0;
  endtask

  // Present one flit and hold it until accepted; returns at the negedge after
  // the accepting edge, where send_out shows that flit.
  task automatic applyStimulus(input logic [FW-1:0] data, input logic [DW-1:0] dest,
                               input logic last, output int cycles);
    bit acc;
    acc      = 1'b0;
    cycles   = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_dest  = dest;
    in_last  = last;
    for (int i = 0; i < 100; i++) begin
      acc = in_ready;
      setCredit();
      @(negedge clk);
      cycles++;
      if (acc) break;
    end
    if (!acc) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept within 100 cycles");
    end
    in_valid  = 1'b0;
    credit_in = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [FW-1:0] rndData();
    return {8{$urandom}};
  endfunction

  initial begin
    int cyc;
    logic [FW-1:0] d;
    #1 rst_n = 1'b0;
    @(negedge clk);
    cmpEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1'b0);
    checkOutput("reset_send_out", send_out, 1'b0);
    checkOutput("reset_credit_err", credit_err, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 3-flit packet to dest 5 with no credits returned
    autoCredit = 0;
    applyStimulus(rndData(), 3'd5, 1'b0, cyc);
    checkOutput("t1_send1", send_out, 1'b1);
    checkOutput("t1_dest1", dest_out, 3'd5);
    checkOutput("t1_tail1", is_tail_out, 1'b0);
    applyStimulus(rndData(), 3'd3, 1'b0, cyc);
    checkOutput("t1_send2", send_out, 1'b1);
    checkOutput("t1_dest2", dest_out, 3'd5);
    checkOutput("t1_tail2", is_tail_out, 1'b0);
    checkOutput("t1_stall_ready", in_ready, 1'b0);
    d = rndData();
    in_valid = 1'b1; in_data = d; in_dest = 3'd0; in_last = 1'b1;
    @(negedge clk);
    checkOutput("t1_stall_send", send_out, 1'b0);
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
    checkOutput("t1_credit_ready", in_ready, 1'b1);
    applyStimulus(d, 3'd0, 1'b1, cyc);
    checkOutput("t1_send3", send_out, 1'b1);
    checkOutput("t1_dest3", dest_out, 3'd5);
    checkOutput("t1_tail3", is_tail_out, 1'b1);
    checkOutput("t1_data3", data_out, d);

    // Back-to-back single-flit packets with continuous credits
    autoCredit = 2;
    idle(3);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(rndData(), 3'(k), 1'b1, cyc);
      checkOutput("t2_cycles", cyc, 1);
      checkOutput("t2_send", send_out, 1'b1);
      checkOutput("t2_dest", dest_out, 3'(k));
      checkOutput("t2_tail", is_tail_out, 1'b1);
    end

    // Body flits carry garbage destinations
    applyStimulus(rndData(), 3'd2, 1'b0, cyc);
    checkOutput("t3_dest_head", dest_out, 3'd2);
    applyStimulus(rndData(), 3'd7, 1'b0, cyc);
    checkOutput("t3_dest_body", dest_out, 3'd2);
    applyStimulus(rndData(), 3'd7, 1'b1, cyc);
    checkOutput("t3_dest_tail", dest_out, 3'd2);
    checkOutput("t3_tail", is_tail_out, 1'b1);
    idle(2);

    // Spurious credit on a full counter
    pulseReset();
    autoCredit = 0;
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
    checkOutput("t4_credit_err", credit_err, 1'b1);
    idle(3);
    checkOutput("t4_credit_err_sticky", credit_err, 1'b1);
    applyStimulus(rndData(), 3'd1, 1'b1, cyc);
    applyStimulus(rndData(), 3'd1, 1'b1, cyc);
    checkOutput("t4_ready_after_two", in_ready, 1'b0);
    in_valid = 1'b1; in_last = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t4_no_third_send", send_out, 1'b0);
    in_valid = 1'b0;

`ifdef NOC_INJECTOR_MAXLEN_EN
    // Over-long packet is truncated, the remainder dropped
    pulseReset();
    autoCredit = 2;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(rndData(), 3'd3, (k == 6), cyc);
      if (k <= 4) begin
        checkOutput("t5_send", send_out, 1'b1);
        checkOutput("t5_tail", is_tail_out, (k == 4));
      end else begin
        checkOutput("t5_drop_send", send_out, 1'b0);
      end
    end
    checkOutput("t5_pkt_err", pkt_err, 1'b1);
    applyStimulus(rndData(), 3'd6, 1'b1, cyc);
    checkOutput("t5_next_send", send_out, 1'b1);
    checkOutput("t5_next_dest", dest_out, 3'd6);
`else
    checkOutput("t5_pkt_err_tied", pkt_err, 1'b0);
`endif

    // Reset asserted mid-packet
    pulseReset();
    autoCredit = 2;
    applyStimulus(rndData(), 3'd4, 1'b0, cyc);
    applyStimulus(rndData(), 3'd4, 1'b0, cyc);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_send", send_out, 1'b0);
    checkOutput("t6_rst_data", data_out, '0);
    checkOutput("t6_rst_dest", dest_out, 3'd0);
    checkOutput("t6_rst_ready", in_ready, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_ready_after", in_ready, 1'b1);
    applyStimulus(rndData(), 3'd6, 1'b0, cyc);
    checkOutput("t6_new_head_dest", dest_out, 3'd6);
    applyStimulus(rndData(), 3'd1, 1'b1, cyc);
    checkOutput("t6_new_tail_dest", dest_out, 3'd6);

    // Randomized traffic with random credit return
    pulseReset();
    autoCredit = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int f = 0; f < len; f++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        applyStimulus(rndData(), 3'($urandom_range(0, 7)), (f == len - 1), cyc);
      end
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
